// File: rtl/pattern_gen_if.sv
// Pattern configuration handshake between a host and pattern_gen.
//   cfg_valid   : host requests a pattern write
//   cfg_ready   : generator accepts writes (high only while idle)
//   cfg_ch      : channel index the write targets
//   cfg_pattern : pattern value, replayed MSB first
interface pattern_gen_if #(
    parameter int PAT_LEN = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [1:0]         cfg_ch;
    logic [PAT_LEN-1:0] cfg_pattern;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_pattern,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_pattern,
        output cfg_ready
    );
endinterface

// File: rtl/pattern_gen.sv
// 4-channel digital sequence generator with trigger output, used as the
// stimulus source for the logic analyser.
//   clk, rst    : system clock, synchronous active-high reset
//   cfg         : pattern write handshake (slave side)
//   div_val     : bit period minus 1, in clk cycles (latched at start)
//   tri_mode    : 1 = rising trigger edge, 0 = falling (latched at start)
//   trig_pos    : bit index within the frame where the edge occurs
//   start, stop : run control pulses; stop finishes the current frame
//   signal      : channel outputs, signal[k] replays pattern k MSB first
//   trigger     : trigger line
//   busy        : high while frames are generated
//   frame_done  : one-cycle pulse on the last clk of each frame
// All outputs are registered.
module pattern_gen #(
    parameter int PAT_LEN = 8,
    parameter int DIV_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    pattern_gen_if.slave     cfg,
    input  logic [DIV_W-1:0] div_val,
    input  logic             tri_mode,
    input  logic [2:0]       trig_pos,
    input  logic             start,
    input  logic             stop,
    output logic [3:0]       signal,
    output logic             trigger,
    output logic             busy,
    output logic             frame_done
);

    localparam int              BIT_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [BIT_W-1:0] LAST = BIT_W'(PAT_LEN - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         state;
    logic [PAT_LEN-1:0] pattern [4];
    logic [DIV_W-1:0]   div_l;
    logic               tri_l;
    logic [2:0]         pos_l;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_nxt;
    logic [DIV_W-1:0]   tick_cnt;
    logic [DIV_W-1:0]   tick_nxt;
    logic               stop_pend;
    logic               cfg_ready_r;
    logic               cfg_wr;
    logic               bit_end;
    logic               frame_end;

    assign cfg.cfg_ready = cfg_ready_r;
    assign cfg_wr        = cfg.cfg_valid && cfg_ready_r;

    // Trigger level for the bit about to be output. Evaluated only on bit
    // advances, so with trig_pos = 0 the first frame keeps the idle level
    // for bit 0 and later frames simply stay at the active level.
    function automatic logic trig_level(input logic [BIT_W-1:0] b,
                                        input logic [2:0]       pos,
                                        input logic             mode);
        return (32'(b) >= 32'(pos)) ? mode : ~mode;
    endfunction

    always_comb begin
        bit_end   = (tick_cnt == div_l);
        frame_end = bit_end && (bit_cnt == LAST);
        tick_nxt  = tick_cnt + DIV_W'(1);
        bit_nxt   = bit_cnt;
        if (bit_end) begin
            tick_nxt = '0;
            bit_nxt  = frame_end ? '0 : bit_cnt + BIT_W'(1);
        end
    end

    // Pattern storage: only writable while idle (cfg_ready high).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) pattern[k] <= '0;
        end else if (cfg_wr) begin
            pattern[cfg.cfg_ch] <= cfg.cfg_pattern;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            div_l       <= '0;
            tri_l       <= 1'b1;
            pos_l       <= '0;
            bit_cnt     <= '0;
            tick_cnt    <= '0;
            stop_pend   <= 1'b0;
            signal      <= '0;
            trigger     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            cfg_ready_r <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    frame_done <= 1'b0;
                    // start wins over a simultaneous stop
                    if (start) begin
                        state       <= ST_RUN;
                        div_l       <= div_val;
                        tri_l       <= tri_mode;
                        pos_l       <= trig_pos;
                        bit_cnt     <= '0;
                        tick_cnt    <= '0;
                        stop_pend   <= 1'b0;
                        busy        <= 1'b1;
                        cfg_ready_r <= 1'b0;
                        trigger     <= ~tri_mode;
                        frame_done  <= (LAST == '0) && (div_val == '0);
                        // A write committing at this same edge feeds the first bit.
                        for (int k = 0; k < 4; k++) begin
                            signal[k] <= (cfg_wr && (cfg.cfg_ch == 2'(k)))
                                         ? cfg.cfg_pattern[PAT_LEN-1]
                                         : pattern[k][PAT_LEN-1];
                        end
                    end
                end
                default: begin
                    if (stop) stop_pend <= 1'b1;
                    if (frame_end && (stop_pend || stop)) begin
                        state       <= ST_IDLE;
                        bit_cnt     <= '0;
                        tick_cnt    <= '0;
                        stop_pend   <= 1'b0;
                        signal      <= '0;
                        trigger     <= ~tri_l;
                        busy        <= 1'b0;
                        frame_done  <= 1'b0;
                        cfg_ready_r <= 1'b1;
                    end else begin
                        tick_cnt   <= tick_nxt;
                        bit_cnt    <= bit_nxt;
                        frame_done <= (bit_nxt == LAST) && (tick_nxt == div_l);
                        for (int k = 0; k < 4; k++) begin
                            signal[k] <= pattern[k][LAST - bit_nxt];
                        end
                        if (bit_end) trigger <= trig_level(bit_nxt, pos_l, tri_l);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
module tb_pattern_gen;

    logic        clk;
    logic        rst;
    logic [15:0] div_val;
    logic        tri_mode;
    logic [2:0]  trig_pos;
    logic        start;
    logic        stop;
    logic [3:0]  signal;
    logic        trigger;
    logic        busy;
    logic        frame_done;

    int n_assert = 0;
    int n_fail   = 0;

    pattern_gen_if #(.PAT_LEN(8)) cfg_if ();

    pattern_gen #(.PAT_LEN(8), .DIV_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg        (cfg_if),
        .div_val    (div_val),
        .tri_mode   (tri_mode),
        .trig_pos   (trig_pos),
        .start      (start),
        .stop       (stop),
        .signal     (signal),
        .trigger    (trigger),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] val);
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_ch      = ch;
        cfg_if.cfg_pattern = val;
        cyc();
        cfg_if.cfg_valid   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            cyc();
            n++;
        end
        chk("wait_idle_busy", busy, 0);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        wait_idle(80);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // A5/0F/FF/00 on ch0..3, one column per bit, {ch3,ch2,ch1,ch0}
    logic [3:0] replay_exp [8];

    initial begin
        replay_exp[0] = 4'b0101; replay_exp[1] = 4'b0100;
        replay_exp[2] = 4'b0101; replay_exp[3] = 4'b0100;
        replay_exp[4] = 4'b0110; replay_exp[5] = 4'b0111;
        replay_exp[6] = 4'b0110; replay_exp[7] = 4'b0111;

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        div_val = 16'd0; tri_mode = 1'b1; trig_pos = 3'd0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_pattern = 8'h00;
        repeat (3) cyc();
        rst = 1'b0;
        chk("init_signal", signal, 0);
        chk("init_trigger", trigger, 0);
        chk("init_busy", busy, 0);
        chk("init_ready", cfg_if.cfg_ready, 1);
        chk("init_fdone", frame_done, 0);

        // reset in the middle of a run
        wr(2'd0, 8'hA5); wr(2'd1, 8'h0F); wr(2'd2, 8'hFF); wr(2'd3, 8'h00);
        do_start();
        chk("run_first_col", signal, 4'b0101);
        chk("run_busy", busy, 1);
        chk("run_ready", cfg_if.cfg_ready, 0);
        repeat (3) cyc();
        rst = 1'b1;
        repeat (4) cyc();
        rst = 1'b0;
        chk("rst_signal", signal, 0);
        chk("rst_trigger", trigger, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_if.cfg_ready, 1);
        chk("rst_fdone", frame_done, 0);

        // patterns were cleared by reset
        do_start();
        for (int i = 0; i < 8; i++) begin
            chk("zero_pat_signal", signal, 0);
            chk("zero_pat_busy", busy, 1);
            cyc();
        end
        do_stop();

        // pattern replay at one bit per clk
        wr(2'd0, 8'hA5); wr(2'd1, 8'h0F); wr(2'd2, 8'hFF); wr(2'd3, 8'h00);
        do_start();
        for (int i = 0; i < 16; i++) begin
            chk("replay_signal", signal, replay_exp[i % 8]);
            chk("replay_fdone", frame_done, (i % 8 == 7) ? 1 : 0);
            cyc();
        end

        // stop while bit 3 is output: frame completes, idle right after frame_done
        repeat (3) cyc();
        chk("stop_at_bit3", signal, replay_exp[3]);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_bit4_busy", busy, 1);
        repeat (3) cyc();
        chk("stop_last_fdone", frame_done, 1);
        chk("stop_last_signal", signal, replay_exp[7]);
        chk("stop_last_busy", busy, 1);
        cyc();
        chk("stop_idle_busy", busy, 0);
        chk("stop_idle_signal", signal, 0);
        chk("stop_idle_trigger", trigger, 0);
        chk("stop_idle_ready", cfg_if.cfg_ready, 1);
        chk("stop_idle_fdone", frame_done, 0);

        // write attempts while busy are dropped
        do_start();
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0; cfg_if.cfg_pattern = 8'h3C;
        repeat (3) begin
            chk("busy_ready_low", cfg_if.cfg_ready, 0);
            cyc();
        end
        cfg_if.cfg_valid = 1'b0;
        do_stop();
        do_start();
        chk("interlock_bit0", signal, replay_exp[0]);
        cyc();
        chk("interlock_bit1", signal, replay_exp[1]);
        do_stop();

        // bit period of 4 clks
        wr(2'd0, 8'h80);
        div_val = 16'd3;
        do_start();
        for (int i = 0; i < 64; i++) begin
            chk("period_sig0", signal[0], (i % 32 < 4) ? 1 : 0);
            chk("period_fdone", frame_done, (i % 32 == 31) ? 1 : 0);
            cyc();
        end
        do_stop();

        // rising trigger at bit 5, two clks per bit
        tri_mode = 1'b1; trig_pos = 3'd5; div_val = 16'd1;
        do_start();
        div_val = 16'd7; tri_mode = 1'b0; trig_pos = 3'd1;   // must not take effect
        for (int i = 0; i < 32; i++) begin
            chk("rise_trigger", trigger, (((i / 2) % 8) >= 5) ? 1 : 0);
            cyc();
        end
        do_stop();
        chk("rise_idle_trigger", trigger, 0);

        // falling trigger at bit 2, one clk per bit
        tri_mode = 1'b0; trig_pos = 3'd2; div_val = 16'd0;
        do_start();
        for (int i = 0; i < 16; i++) begin
            chk("fall_trigger", trigger, ((i % 8) < 2) ? 1 : 0);
            cyc();
        end
        do_stop();
        chk("fall_idle_trigger", trigger, 1);

        // trig_pos 0: first frame edge one bit period in, then held high
        tri_mode = 1'b1; trig_pos = 3'd0; div_val = 16'd1;
        do_start();
        for (int i = 0; i < 32; i++) begin
            chk("pos0_trigger", trigger, (i >= 2) ? 1 : 0);
            cyc();
        end
        do_stop();

        // start together with a write and a stop in idle
        div_val = 16'd0;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd1; cfg_if.cfg_pattern = 8'h80;
        stop = 1'b1;
        do_start();
        cfg_if.cfg_valid = 1'b0;
        stop = 1'b0;
        chk("startwr_sig1_bit0", signal[1], 1);
        cyc();
        chk("startwr_sig1_bit1", signal[1], 0);
        repeat (9) cyc();
        chk("start_beats_stop_busy", busy, 1);
        chk("start_beats_stop_sig1", signal[1], 0);
        do_stop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
